// File: rtl/rv64_pkg.sv
// Shared RV64 pipeline definitions: widths, reset vector and the fetch-to-decode entry.
package rv64_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handshake.
interface fetch_unit_if;
  import rv64_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetched {pc, instr} entries with flush and a registered head.
module fetch_fifo
  import rv64_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output logic                         head_valid,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = next_ptr(wr_q);
      end
      if (pop) rd_d = next_ptr(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head is forced to zero when empty so decode sees clean values after reset or flush.
  assign head_valid = (cnt_q != '0);
  assign head       = head_valid ? mem_q[rd_q] : '0;
  assign count      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// RV64 instruction-fetch stage: PC registers, credit-limited request issue,
// stale-response dropping on redirect, and the buffer toward decode.
module fetch_unit
  import rv64_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flow_change,
  input  logic [XLEN-1:0]  next_pc,
  fetch_unit_if.master     bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] target;
  logic            credit_ok, req_fire, push, pop, head_valid;
  fetch_entry_t    push_entry, head;
  logic            unused_pc_bits;

  assign target         = {next_pc[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^next_pc[1:0];

  assign credit_ok          = ({1'b0, inflight_q} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign bus.imem_req_valid = rst_n & ~flow_change & credit_ok;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
  assign pop                = head_valid & bus.if_ready & ~flow_change;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};
    if (flow_change) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      inflight_d = inflight_q - CW'(bus.imem_rsp_valid);
      // Already-dropping responses are counted in inflight, so every outstanding one turns stale.
      drop_d     = inflight_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
      inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + 64'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flow_change),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head),
    .count      (count)
  );

  assign bus.if_valid = head_valid;
  assign bus.if_instr = head.instr;
  assign bus.if_pc    = head.pc;

endmodule
